// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit with HI/LO registers.
// Fixed-latency mult/div, mthi/mtlo writes, combinational mfhi/mflo.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_busy,
  output logic [31:0] E_MDUout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d;
  logic [31:0]   lo_tmp_q, lo_tmp_d;

  logic          is_mul;
  logic          is_div;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          b_zero;
  logic [31:0]   dvs_u;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   sq;
  logic [31:0]   sr;
  logic [31:0]   q_s;
  logic [31:0]   r_s;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign is_mul = (E_MDUOp == OP_MULT) ||
                  (E_MDUOp == OP_MULTU);
  assign is_div = (E_MDUOp == OP_DIV) ||
                  (E_MDUOp == OP_DIVU);

  assign prod_s = $signed({{32{E_A[31]}}, E_A}) *
                  $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Zero divisor is replaced by 1 so the datapath never sees X;
  // the result is discarded in that case anyway.
  assign b_zero = (E_B == 32'd0);
  assign dvs_u  = b_zero ? 32'd1 : E_B;

  assign a_neg = E_A[31];
  assign b_neg = E_B[31];
  assign a_mag = a_neg ? (32'd0 - E_A) : E_A;
  assign b_mag = b_neg ? (32'd0 - E_B) : dvs_u;

  assign sq  = a_mag / b_mag;
  assign sr  = a_mag % b_mag;
  assign q_s = (a_neg ^ b_neg) ? (32'd0 - sq) : sq;
  assign r_s = a_neg ? (32'd0 - sr) : sr;

  assign uq = E_A / dvs_u;
  assign ur = E_A % dvs_u;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (E_MDUOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (!b_zero) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      IDLE: begin
        if (E_start && (is_mul || is_div)) begin
          state_d  = BUSY;
          cnt_d    = is_div ? CW'(DIV_CYCLES)
                            : CW'(MULT_CYCLES);
          hi_tmp_d = res_hi;
          lo_tmp_d = res_lo;
        end else if (E_MDUOp == OP_MTHI) begin
          hi_d = E_A;
        end else if (E_MDUOp == OP_MTLO) begin
          lo_d = E_A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  always_comb begin
    E_MDUout = 32'd0;
    case (E_MDUOp)
      OP_MFHI: E_MDUout = hi_q;
      OP_MFLO: E_MDUout = lo_q;
      default: ;
    endcase
  end

  assign E_busy = (state_q == BUSY);
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Completed operations are checked by a monitor on busy falling.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] mduout;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .E_MDUOp(op),
    .E_start(start),
    .E_A(a),
    .E_B(b),
    .E_busy(busy),
    .E_MDUout(mduout),
    .HI(hi),
    .LO(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO when busy falls.
  initial begin : monitor
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (busy) begin
          run++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got op end, expected none");
          end else begin
            e = sb.pop_front();
            chk({e.name, "_cycles"}, 32'(run), 32'(e.cycles));
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_lo"}, lo, e.lo);
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic start_op(input string nm,
                          input logic [3:0] o,
                          input logic [31:0] va,
                          input logic [31:0] vb,
                          input logic [31:0] ehi,
                          input logic [31:0] elo,
                          input int ecyc);
    exp_t e;
    e.name   = nm;
    e.hi     = ehi;
    e.lo     = elo;
    e.cycles = ecyc;
    sb.push_back(e);
    op    = o;
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 4'd0;
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy, expected idle", nm);
    end
  endtask

  task automatic idle_cyc();
    op    = 4'd0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    reset = 1'b1;
    op    = 4'd0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    op = 4'd5; #1;
    chk("rst_mfhi", mduout, 32'd0);
    op = 4'd0; #1;
    chk("rst_none_out", mduout, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    start_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3,
             32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    wait_idle("mult");
    op = 4'd5; #1;
    chk("mult_mfhi", mduout, 32'hFFFFFFFF);
    op = 4'd6; #1;
    chk("mult_mflo", mduout, 32'hFFFFFFFA);
    idle_cyc();

    start_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2,
             32'h00000001, 32'hFFFFFFFE, 5);
    wait_idle("multu");
    idle_cyc();

    start_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle("div_neg");
    idle_cyc();

    start_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000, 10);
    wait_idle("div_ovf");
    idle_cyc();

    start_op("divu", 4'd4, 32'd100, 32'd7,
             32'd2, 32'd14, 10);
    wait_idle("divu");
    idle_cyc();

    // divide by zero, with writes and a start arriving while busy
    start_op("div0", 4'd3, 32'd5, 32'd0,
             32'd2, 32'd14, 10);
    op = 4'd8; a = 32'hDEAD;
    @(posedge clk); #1;
    op = 4'd7; a = 32'hBEEF;
    @(posedge clk); #1;
    op = 4'd1; start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'd6; #1;
    chk("busy_mflo_old", mduout, 32'd14);
    op = 4'd0;
    wait_idle("div0");
    idle_cyc();

    op = 4'd7; a = 32'h1234;
    @(posedge clk); #1;
    op = 4'd6; #1;
    chk("mt_mflo", mduout, 32'd14);
    op = 4'd5; #1;
    chk("mt_mfhi", mduout, 32'h1234);
    idle_cyc();

    start_op("mult_mtlo", 4'd1, 32'd3, 32'd4,
             32'd0, 32'd12, 5);
    op = 4'd8; a = 32'h55;
    @(posedge clk); #1;
    op = 4'd0;
    wait_idle("mult_mtlo");
    start_op("b2b", 4'd1, 32'd5, 32'd6,
             32'd0, 32'd30, 5);
    wait_idle("b2b");
    idle_cyc();

    op = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    chk("start_nonmd", 32'(busy), 32'd0);
    op = 4'd1; start = 1'b0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    chk("md_nostart", 32'(busy), 32'd0);
    op = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    chk("op9_start", 32'(busy), 32'd0);
    idle_cyc();
    chk("ignored_lo", lo, 32'd30);

    op = 4'd1; start = 1'b1; a = 32'd7; b = 32'd7;
    @(posedge clk); #1;
    idle_cyc();
    idle_cyc();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    @(negedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
